// File: rtl/prior_pkg.sv
// prior_pkg: shared types and widths for prior_decoder and its decode helper.
//   state_e    : FSM states (IDLE=0, DRIVE=1, GAP=2), 2 bits
//   code_buf_t : one-entry input buffer slot (valid + code)
//   CODE_W / OUT_W / CNT_W : code, one-hot output and counter widths
package prior_pkg;
  localparam int CODE_W = 2;
  localparam int OUT_W  = 4;
  localparam int CNT_W  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } state_e;

  typedef struct packed {
    logic              vld;
    logic [CODE_W-1:0] code;
  } code_buf_t;
endpackage

// File: rtl/prior_decoder_onehot_dec.sv
// onehot_dec: pure combinational 2-to-4 one-hot decode.
//   code : encoded index
//   y    : y[code] = 1, all other lines 0
module onehot_dec
  import prior_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  output logic [OUT_W-1:0]  y
);
  for (genvar i = 0; i < OUT_W; i++) begin : g_line
    assign y[i] = (code == CODE_W'(i));
  end
endmodule

// File: rtl/prior_decoder.sv
// prior_decoder: registered 2-to-4 one-hot decoder with timed pulse and gap.
// Accepts a code over valid/ready, drives y[code] for PULSE_LEN cycles, then
// forces y to zero for GAP_LEN cycles.
//   clk, rst   : clock, synchronous active-high reset
//   code_valid : code is offered this cycle
//   code       : encoded index to decode
//   code_ready : block can accept a code this cycle
//   y          : one-hot line, live only in DRIVE
//   busy       : high in DRIVE or GAP
//   done       : pulse on the last DRIVE cycle of each pulse
// Optional macro PRIOR_DECODER_BUFFER_EN adds a one-entry input buffer so a
// code can be taken while a pulse/gap is in flight and launched with no IDLE
// cycle in between.
module prior_decoder
  import prior_pkg::*;
#(
  parameter int PULSE_LEN = 4,
  parameter int GAP_LEN   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              code_valid,
  input  logic [CODE_W-1:0] code,
  output logic              code_ready,
  output logic [OUT_W-1:0]  y,
  output logic              busy,
  output logic              done
);
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_LEN - 1);
  localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);

  state_e            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [CODE_W-1:0] cur, cur_n;
  logic [OUT_W-1:0]  dec;
  logic              accept, last, wrap;

  assign accept = code_valid && code_ready;
  assign last   = (cnt == '0);
  // wrap: this edge would return the FSM to IDLE
  assign wrap   = last && ((state == GAP) || (state == DRIVE && GAP_LEN == 0));

`ifdef PRIOR_DECODER_BUFFER_EN
  code_buf_t buf_q, buf_n;
  assign code_ready = !buf_q.vld;
`else
  assign code_ready = (state == IDLE);
`endif

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    cur_n   = cur;
`ifdef PRIOR_DECODER_BUFFER_EN
    buf_n   = buf_q;
`endif
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_n = DRIVE;
          cnt_n   = PULSE_LD;
          cur_n   = code;
        end
      end
      DRIVE: begin
        if (!last) cnt_n = cnt - 1'b1;
        else if (GAP_LEN > 0) begin
          state_n = GAP;
          cnt_n   = GAP_LD;
        end
      end
      GAP: begin
        if (!last) cnt_n = cnt - 1'b1;
      end
      default: state_n = IDLE;
    endcase

    if (wrap) begin
      state_n = IDLE;
      cnt_n   = '0;
`ifdef PRIOR_DECODER_BUFFER_EN
      // Chain straight into the next pulse: buffered code first, else a code
      // arriving on this very edge bypasses the buffer.
      if (buf_q.vld) begin
        state_n   = DRIVE;
        cnt_n     = PULSE_LD;
        cur_n     = buf_q.code;
        buf_n.vld = 1'b0;
      end else if (accept) begin
        state_n = DRIVE;
        cnt_n   = PULSE_LD;
        cur_n   = code;
      end
`endif
    end

`ifdef PRIOR_DECODER_BUFFER_EN
    if (accept && state != IDLE && !wrap) buf_n = '{vld: 1'b1, code: code};
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      cur   <= '0;
`ifdef PRIOR_DECODER_BUFFER_EN
      buf_q <= '0;
`endif
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      cur   <= cur_n;
`ifdef PRIOR_DECODER_BUFFER_EN
      buf_q <= buf_n;
`endif
    end
  end

  onehot_dec u_dec (.code(cur), .y(dec));

  assign y    = (state == DRIVE) ? dec : '0;
  assign busy = (state != IDLE);
  assign done = (state == DRIVE) && last;
endmodule

// File: tb/tb_prior_decoder.sv
// tb_prior_decoder: two instances (PULSE_LEN/GAP_LEN = 4/1 and 1/0) checked
// every cycle against a timeline model: each accepted code books its pulse,
// done and busy cycles into per-cycle expectation arrays; directed literal
// checks pin the model. Honours PRIOR_DECODER_BUFFER_EN.
module tb_prior_decoder;
  localparam int MAXC = 4096;

  logic       clk = 1'b0;
  logic       rst_v  [2];
  logic       vld_v  [2];
  logic [1:0] code_v [2];
  logic       rdy_v  [2];
  logic [3:0] y_v    [2];
  logic       busy_v [2];
  logic       done_v [2];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  prior_decoder #(.PULSE_LEN(4), .GAP_LEN(1)) dut_a (
    .clk(clk), .rst(rst_v[0]), .code_valid(vld_v[0]), .code(code_v[0]),
    .code_ready(rdy_v[0]), .y(y_v[0]), .busy(busy_v[0]), .done(done_v[0]));

  prior_decoder #(.PULSE_LEN(1), .GAP_LEN(0)) dut_b (
    .clk(clk), .rst(rst_v[1]), .code_valid(vld_v[1]), .code(code_v[1]),
    .code_ready(rdy_v[1]), .y(y_v[1]), .busy(busy_v[1]), .done(done_v[1]));

  function automatic int plen(int i); return (i == 0) ? 4 : 1; endfunction
  function automatic int glen(int i); return (i == 0) ? 1 : 0; endfunction

  // Model: cycle c is the interval after edge c.
  logic [3:0] ey [2][MAXC];
  bit         ed [2][MAXC];
  bit         eb [2][MAXC];
  int         free_e [2];   // edge at which the instance would re-enter IDLE
  int         pend   [2];   // launch edge of the latest accepted code
  bit         acc    [2];
  int         edge_cnt = -1;

  function automatic bit mready(int i, int c);
`ifdef PRIOR_DECODER_BUFFER_EN
    return !(pend[i] > c);
`else
    return c >= free_e[i];
`endif
  endfunction

  task automatic chk(input string name, input int i, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] cyc=%0d got=%0h want=%0h", name, i, edge_cnt, act, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      free_e[i] = 0; pend[i] = 0; acc[i] = 0;
      for (int k = 0; k < MAXC; k++) begin ey[i][k] = 0; ed[i][k] = 0; eb[i][k] = 0; end
    end
    forever begin
      @(posedge clk);
      edge_cnt++;
      for (int i = 0; i < 2; i++) begin
        acc[i] = 0;
        if (rst_v[i]) begin
          for (int k = edge_cnt; k < MAXC; k++) begin ey[i][k] = 0; ed[i][k] = 0; eb[i][k] = 0; end
          free_e[i] = edge_cnt;
          pend[i]   = 0;
        end else if (vld_v[i] && mready(i, edge_cnt - 1)) begin
          int l;
          l = (edge_cnt > free_e[i]) ? edge_cnt : free_e[i];
          for (int k = 0; k < plen(i) + glen(i); k++) begin
            if (l + k < MAXC) begin
              eb[i][l+k] = 1;
              if (k < plen(i)) ey[i][l+k] = 4'd1 << code_v[i];
              if (k == plen(i) - 1) ed[i][l+k] = 1;
            end
          end
          free_e[i] = l + plen(i) + glen(i);
          pend[i]   = l;
          acc[i]    = 1;
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (edge_cnt >= 0 && edge_cnt < MAXC) begin
      for (int i = 0; i < 2; i++) begin
        chk("y",     i, int'(y_v[i]),    int'(ey[i][edge_cnt]));
        chk("busy",  i, int'(busy_v[i]), int'(eb[i][edge_cnt]));
        chk("done",  i, int'(done_v[i]), int'(ed[i][edge_cnt]));
        chk("ready", i, int'(rdy_v[i]),  int'(mready(i, edge_cnt)));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int i, input logic [1:0] c);
    vld_v[i]  = 1'b1;
    code_v[i] = c;
    for (int n = 0; n < 100; n++) begin
      tick();
      if (acc[i]) begin
        vld_v[i] = 1'b0;
        return;
      end
    end
    vld_v[i] = 1'b0;
    bad++;
    total++;
    $display("FAIL accept_timeout[%0d] cyc=%0d got=no_accept want=accept", i, edge_cnt);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin rst_v[i] = 1'b1; vld_v[i] = 1'b0; code_v[i] = 2'b00; end

    // Reset and hold with a code offered
    vld_v[0] = 1'b1; code_v[0] = 2'b10;
    repeat (3) begin
      tick();
      chk("rst_y", 0, int'(y_v[0]), 0);
      chk("rst_busy", 0, int'(busy_v[0]), 0);
      chk("rst_done", 0, int'(done_v[0]), 0);
    end
    vld_v[0] = 1'b0;
    rst_v[0] = 1'b0; rst_v[1] = 1'b0;
    tick();
    chk("rel_ready", 0, int'(rdy_v[0]), 1);
    chk("rel_ready", 1, int'(rdy_v[1]), 1);

    // Single code 10: 4 cycles of 0100, done on the 4th, one gap, then IDLE
    send(0, 2'b10);
    for (int k = 0; k < 4; k++) begin
      chk("pulse_y", 0, int'(y_v[0]), 4'b0100);
      chk("pulse_done", 0, int'(done_v[0]), (k == 3) ? 1 : 0);
      tick();
    end
    chk("gap_y", 0, int'(y_v[0]), 0);
    chk("gap_busy", 0, int'(busy_v[0]), 1);
    tick();
    chk("idle_ready", 0, int'(rdy_v[0]), 1);
    chk("idle_busy", 0, int'(busy_v[0]), 0);

    // Sweep: back-to-back and spaced codes on both instances
    for (int n = 0; n < 100; n++) begin
      logic [1:0] c;
      c = (n < 8) ? 2'(n) : 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) tick();
      send(0, c);
      if (n < 30) send(1, 2'($urandom_range(0, 3)));
    end
    repeat (10) tick();

    // PULSE_LEN=1, GAP_LEN=0 boundary
    send(1, 2'b11);
    chk("b_y", 1, int'(y_v[1]), 4'b1000);
    chk("b_done", 1, int'(done_v[1]), 1);
    tick();
    chk("b_idle_y", 1, int'(y_v[1]), 0);
    chk("b_idle_busy", 1, int'(busy_v[1]), 0);
    chk("b_idle_ready", 1, int'(rdy_v[1]), 1);

    // Reset in DRIVE cycle 2 aborts the pulse for good
    send(0, 2'b01);
    chk("mid_y0", 0, int'(y_v[0]), 4'b0010);
    tick();
    chk("mid_y1", 0, int'(y_v[0]), 4'b0010);
    rst_v[0] = 1'b1;
    tick();
    rst_v[0] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("abort_y", 0, int'(y_v[0]), 0);
      chk("abort_busy", 0, int'(busy_v[0]), 0);
      tick();
    end

`ifdef PRIOR_DECODER_BUFFER_EN
    // Buffered: 01 then 11 during DRIVE -> 0010 x4, gap, 1000 x4
    send(0, 2'b01);
    send(0, 2'b11);
    chk("buf_full_ready", 0, int'(rdy_v[0]), 0);
    for (int k = 1; k < 4; k++) begin
      chk("buf_y1", 0, int'(y_v[0]), 4'b0010);
      tick();
    end
    chk("buf_gap_y", 0, int'(y_v[0]), 0);
    chk("buf_gap_ready", 0, int'(rdy_v[0]), 0);
    tick();
    for (int k = 0; k < 4; k++) begin
      chk("buf_y2", 0, int'(y_v[0]), 4'b1000);
      chk("buf_y2_ready", 0, int'(rdy_v[0]), 1);
      tick();
    end
`endif

    repeat (10) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d got=running want=finished", edge_cnt);
    $fatal(1, "watchdog");
  end
endmodule
